// File: rtl/ifetch_queue_nw.sv
`default_nettype none
// ============================================================================
// Module : ifetch_queue_nw
// N-wide fetch stage: truncating group enqueue into a circular fetch queue,
// multi-slot drain to decode, redirects deferred while a miss is in flight.
// Rev    : 1.0
// ============================================================================
module ifetch_queue_nw #(
  parameter int PC_BITS     = 32,
  parameter int INSTR_BITS  = 32,
  parameter int FETCH_INSTR = 4,
  parameter int OUT_INSTR   = 2,
  parameter int FQ_DEPTH    = 8,
  parameter logic [PC_BITS-1:0] RESET_PC = '0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  output logic [PC_BITS-1:0]                            current_pc,
  input  logic                                          hit_cache,
  input  logic                                          miss,
  input  logic [$clog2(FETCH_INSTR):0]                  cache_avail,
  input  logic [FETCH_INSTR*INSTR_BITS-1:0]             fetched_data,
  input  logic [FETCH_INSTR-1:0]                        pred_taken,
  input  logic [PC_BITS-1:0]                            pred_target,
  input  logic                                          must_flush,
  input  logic [PC_BITS-1:0]                            correct_address,
  input  logic                                          invalid_prediction,
  input  logic                                          invalid_instruction,
  input  logic [PC_BITS-1:0]                            old_pc,
  output logic [OUT_INSTR*(PC_BITS+INSTR_BITS+1)-1:0]   data_out,
  output logic [OUT_INSTR-1:0]                          out_valid,
  output logic                                          valid_o,
  input  logic                                          ready_in,
  output logic [$clog2(FQ_DEPTH):0]                     fq_count
);

  localparam int OFF_W = $clog2(FETCH_INSTR);
  localparam int CW    = $clog2(FQ_DEPTH) + 1;
  localparam int PW    = CW - 1;
  localparam int EW    = PC_BITS + INSTR_BITS + 1;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_PEND_LOW  = 2'd1,
    S_PEND_HIGH = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PC_BITS-1:0] saved_pc, saved_nxt, pc_nxt;

  logic [EW-1:0]      mem [FQ_DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count;

  logic [OFF_W-1:0]   off;
  logic [CW-1:0]      room, free, k, tk, npop;
  logic               found, take_acc;
  logic               redirect, do_enq, do_pop;
  logic [PC_BITS-1:0] tgt;

  assign off      = current_pc[OFF_W+1:2];
  assign redirect = must_flush | invalid_prediction | invalid_instruction;
  assign tgt      = must_flush ? correct_address : old_pc;

  // Accept count: limited by cache data, block end, free space (pre-pop) and the first taken slot
  always_comb begin
    room  = CW'(FETCH_INSTR) - CW'(off);
    free  = CW'(FQ_DEPTH) - count;
    k     = (CW'(cache_avail) < room) ? CW'(cache_avail) : room;
    if (free < k) k = free;
    found = 1'b0;
    tk    = '0;
    for (int i = 0; i < FETCH_INSTR; i++) begin
      if (!found && (i >= int'(off)) && pred_taken[i]) begin
        found = 1'b1;
        tk    = CW'(i - int'(off) + 1);
      end
    end
    take_acc = found && (tk <= k);
    if (take_acc) k = tk;
  end

  assign do_enq = hit_cache & ~miss & (state == S_RUN) & ~redirect & (k != '0);
  assign do_pop = valid_o & ready_in & ~redirect;
  assign npop   = (count > CW'(OUT_INSTR)) ? CW'(OUT_INSTR) : count;

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + PW'(npop);
      if (do_enq) wr_ptr <= wr_ptr + PW'(k);
      count <= count + (do_enq ? k : '0) - (do_pop ? npop : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      for (int j = 0; j < FETCH_INSTR; j++) begin
        if (CW'(j) < k)
          mem[wr_ptr + PW'(j)] <= {take_acc && (CW'(j) == k - 1'b1),
                                   current_pc + PC_BITS'(4 * j),
                                   fetched_data[(int'(off) + j)*INSTR_BITS +: INSTR_BITS]};
      end
    end
  end

  for (genvar g = 0; g < OUT_INSTR; g++) begin : g_out
    assign data_out[g*EW +: EW] = mem[rd_ptr + PW'(g)];
    assign out_valid[g]         = (count > CW'(g));
  end

  assign valid_o  = out_valid[0];
  assign fq_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      current_pc <= RESET_PC;
      saved_pc   <= RESET_PC;
    end else begin
      state      <= state_nxt;
      current_pc <= pc_nxt;
      saved_pc   <= saved_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = current_pc;
    saved_nxt = saved_pc;
    case (state)
      S_RUN: begin
        if (redirect) begin
          if (!miss) begin
            pc_nxt = tgt;
          end else begin
            saved_nxt = tgt;
            state_nxt = must_flush ? S_PEND_HIGH : S_PEND_LOW;
          end
        end else if (do_enq) begin
          pc_nxt = take_acc ? pred_target : current_pc + (PC_BITS'(k) << 2);
        end
      end
      default: begin
        // Only a flush may replace a deferred target; the pending cache data is dropped
        if (must_flush) begin
          saved_nxt = correct_address;
          state_nxt = S_PEND_HIGH;
        end
        if (!miss) begin
          pc_nxt    = must_flush ? correct_address : saved_pc;
          state_nxt = S_RUN;
        end
      end
    endcase
  end

endmodule
`default_nettype wire
